// File: rtl/wb_burst_reader_if.sv
// -----------------------------------------------------------------------------
// wb_burst_reader_if
// Wishbone B4 read-burst bus between the burst reader (initiator) and the
// SDRAM responder.
//   wb_adr_o  byte address of the current beat (initiator -> responder)
//   wb_cyc_o  bus cycle
//   wb_stb_o  strobe, mirrors wb_cyc_o
//   wb_we_o   write enable, always 0 (read-only initiator)
//   wb_sel_o  byte selects, always all ones
//   wb_cti_o  cycle type: incrementing burst, end-of-burst, or classic
//   wb_dat_i  read data (responder -> initiator)
//   wb_ack_i  beat acknowledge (responder -> initiator)
// -----------------------------------------------------------------------------
interface wb_burst_reader_if #(
  parameter int ADR_W  = 24,
  parameter int DATA_W = 32
);
  logic [ADR_W-1:0]  wb_adr_o;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [3:0]        wb_sel_o;
  logic [2:0]        wb_cti_o;
  logic [DATA_W-1:0] wb_dat_i;
  logic              wb_ack_i;

  modport master (
    output wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_cti_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/wb_burst_reader.sv
// -----------------------------------------------------------------------------
// wb_burst_reader
// Wishbone initiator that streams a linear, 16-byte aligned SDRAM region into
// a show-ahead FIFO using 4-beat incrementing read bursts. A burst is only
// issued when the FIFO can absorb all of its beats, so the FIFO never
// overflows and the responder is never stalled by the consumer.
// Ports:
//   wb_clk, wb_rst_n   clock, asynchronous active-low reset
//   start, abort       1-cycle control pulses
//   base_adr, n_bursts transfer start address and burst count (0 = empty)
//   busy, done         transfer in progress / 1-cycle normal completion pulse
//   wb                 wishbone initiator bus (master modport)
//   q_rd               consumer pop
//   q_dat, q_empty     FIFO head word and empty flag
//   q_level            words held in the FIFO
// -----------------------------------------------------------------------------
module wb_burst_reader #(
  parameter int ADR_W     = 24,
  parameter int LEN_W     = 14,
  parameter int FIFO_LOG2 = 4,
  parameter int BURST_LEN = 4,
  parameter int DATA_W    = 32
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADR_W-1:0]     base_adr,
  input  logic [LEN_W-1:0]     n_bursts,
  output logic                 busy,
  output logic                 done,
  wb_burst_reader_if.master    wb,
  input  logic                 q_rd,
  output logic [DATA_W-1:0]    q_dat,
  output logic                 q_empty,
  output logic [FIFO_LOG2:0]   q_level
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int LVL_W = FIFO_LOG2 + 1;
  localparam int PTR_W = FIFO_LOG2;
  localparam logic [LVL_W-1:0] SPACE_MAX   = LVL_W'(DEPTH - BURST_LEN);
  localparam logic [1:0]       LAST_BEAT   = 2'(BURST_LEN - 1);
  localparam logic [2:0]       CTI_CLASSIC = 3'b000;
  localparam logic [2:0]       CTI_INCR    = 3'b010;
  localparam logic [2:0]       CTI_END     = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_WAIT_SPACE, S_BURST, S_FLUSH} state_t;

  state_t             state_q, state_d;
  logic [ADR_W-1:0]   adr_q, adr_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [1:0]         beat_q, beat_d;
  logic               cyc_q, cyc_d;
  logic [2:0]         cti_q, cti_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               abort_pend_q, abort_pend_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [DATA_W-1:0]  fifo_mem [DEPTH];

  logic beat_ack, last_ack, last_burst, abort_now, has_space;
  logic push, pop, flush;

  function automatic logic [2:0] cti_for_beat(input logic [1:0] beat);
    return (beat == LAST_BEAT) ? CTI_END : CTI_INCR;
  endfunction

  assign beat_ack   = (state_q == S_BURST) && wb.wb_ack_i;
  assign last_ack   = beat_ack && (beat_q == LAST_BEAT);
  assign last_burst = (remaining_q == LEN_W'(1));
  // abort is sticky; a pulse in the current cycle counts as already latched
  assign abort_now  = abort_pend_q | abort;
  assign has_space  = (level_q <= SPACE_MAX);
  assign push       = beat_ack;
  assign pop        = q_rd && !q_empty;

  // ---- state / control registers
  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q      <= S_IDLE;
      adr_q        <= '0;
      remaining_q  <= '0;
      beat_q       <= '0;
      cyc_q        <= 1'b0;
      cti_q        <= CTI_CLASSIC;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      abort_pend_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      adr_q        <= adr_d;
      remaining_q  <= remaining_d;
      beat_q       <= beat_d;
      cyc_q        <= cyc_d;
      cti_q        <= cti_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      abort_pend_q <= abort_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
    end
  end

  // ---- FIFO storage (data only, no reset)
  always_ff @(posedge wb_clk) begin
    if (push) fifo_mem[wr_ptr_q] <= wb.wb_dat_i;
  end

  // ---- next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:       if (start && (n_bursts != '0)) state_d = S_WAIT_SPACE;
      S_WAIT_SPACE: begin
        if (abort_now)      state_d = S_FLUSH;
        else if (has_space) state_d = S_BURST;
      end
      S_BURST: begin
        // cyc is never dropped before the final ack, so abort waits here
        if (last_ack) begin
          if (abort_now)       state_d = S_FLUSH;
          else if (last_burst) state_d = S_IDLE;
          else                 state_d = S_WAIT_SPACE;
        end
      end
      S_FLUSH:      state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // ---- output / datapath next values
  always_comb begin
    adr_d        = adr_q;
    remaining_d  = remaining_q;
    beat_d       = beat_q;
    cyc_d        = cyc_q;
    cti_d        = cti_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    abort_pend_d = abort_pend_q;
    flush        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        abort_pend_d = 1'b0;
        if (start) begin
          if (n_bursts == '0) begin
            done_d = 1'b1;
          end else begin
            adr_d        = {base_adr[ADR_W-1:4], 4'h0};
            remaining_d  = n_bursts;
            busy_d       = 1'b1;
            abort_pend_d = abort;
          end
        end
      end
      S_WAIT_SPACE: begin
        abort_pend_d = abort_now;
        if (!abort_now && has_space) begin
          cyc_d  = 1'b1;
          beat_d = '0;
          cti_d  = cti_for_beat(2'd0);
        end
      end
      S_BURST: begin
        abort_pend_d = abort_now;
        if (beat_ack) begin
          adr_d  = adr_q + ADR_W'(4);
          beat_d = beat_q + 2'd1;
          cti_d  = cti_for_beat(beat_q + 2'd1);
          if (last_ack) begin
            // registered deassert: cyc/stb are low on the edge that takes the last ack
            cyc_d       = 1'b0;
            cti_d       = CTI_CLASSIC;
            remaining_d = remaining_q - LEN_W'(1);
            if (!abort_now && last_burst) begin
              done_d = 1'b1;
              busy_d = 1'b0;
            end
          end
        end
      end
      S_FLUSH: begin
        busy_d       = 1'b0;
        abort_pend_d = 1'b0;
        flush        = 1'b1;
      end
      default: ;
    endcase
  end

  // ---- FIFO pointer / level next values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
  end

  a_no_push_at_full: assert property (@(posedge wb_clk) disable iff (!wb_rst_n)
    !(push && (level_q == LVL_W'(DEPTH))));

  assign wb.wb_adr_o = adr_q;
  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_we_o  = 1'b0;
  assign wb.wb_sel_o = 4'hF;
  assign wb.wb_cti_o = cti_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign q_dat       = fifo_mem[rd_ptr_q];
  assign q_empty     = (level_q == '0);
  assign q_level     = level_q;
endmodule

// File: tb/tb_wb_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_reader
// Scoreboard bench for wb_burst_reader. Stimulus pushes the expected bus beats
// (address, cti) and the expected FIFO words; independent monitors compare the
// bus at every cycle of an open cycle and the FIFO head at every pop.
// The responder returns {8'hD0, address} as data, with programmable waits.
// -----------------------------------------------------------------------------
module tb_wb_burst_reader;
  localparam int ADR_W     = 24;
  localparam int LEN_W     = 14;
  localparam int FIFO_LOG2 = 4;
  localparam int DATA_W    = 32;

  typedef struct {
    logic [23:0] adr;
    logic [2:0]  cti;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [23:0]       base_adr = '0;
  logic [13:0]       n_bursts = '0;
  logic              busy;
  logic              done;
  logic              q_rd = 1'b0;
  logic [31:0]       q_dat;
  logic              q_empty;
  logic [4:0]        q_level;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int waits = 0;

  beat_t       exp_beat[$];
  logic [31:0] exp_dat[$];

  always #5 clk = ~clk;

  wb_burst_reader_if #(.ADR_W(ADR_W), .DATA_W(DATA_W)) bus ();

  wb_burst_reader #(
    .ADR_W(ADR_W), .LEN_W(LEN_W), .FIFO_LOG2(FIFO_LOG2), .BURST_LEN(4), .DATA_W(DATA_W)
  ) dut (
    .wb_clk(clk), .wb_rst_n(rst_n), .start(start), .abort(abort),
    .base_adr(base_adr), .n_bursts(n_bursts), .busy(busy), .done(done),
    .wb(bus), .q_rd(q_rd), .q_dat(q_dat), .q_empty(q_empty), .q_level(q_level)
  );

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {8'hD0, a};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic expect_burst(input logic [23:0] a0, input bit with_data);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.adr = a0 + 24'(4 * i);
      b.cti = (i == 3) ? 3'b111 : 3'b010;
      exp_beat.push_back(b);
      if (with_data) exp_dat.push_back(mem_word(b.adr));
    end
  endtask

  // Responder: acts 2 ns after the edge so stimulus polling at +1 ns sees
  // the ack value that the DUT just sampled.
  initial begin
    int wcnt;
    wcnt = 0;
    bus.wb_ack_i = 1'b0;
    bus.wb_dat_i = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n || !bus.wb_cyc_o) begin
        bus.wb_ack_i = 1'b0;
        wcnt = 0;
      end else begin
        if (bus.wb_ack_i) wcnt = 0;
        if (wcnt >= waits) begin
          bus.wb_ack_i = 1'b1;
          bus.wb_dat_i = mem_word(bus.wb_adr_o);
        end else begin
          bus.wb_ack_i = 1'b0;
          wcnt++;
        end
      end
    end
  end

  // Bus monitor: address/cti must match the pending beat on every cycle of
  // an open bus cycle (stable through wait states), popped on ack.
  always @(negedge clk) begin
    if (rst_n && bus.wb_cyc_o) begin
      chk("beat_pending", 32'(exp_beat.size() != 0), 32'd1);
      if (exp_beat.size() != 0) begin
        chk("wb_adr", 32'(bus.wb_adr_o), 32'(exp_beat[0].adr));
        chk("wb_cti", 32'(bus.wb_cti_o), 32'(exp_beat[0].cti));
        if (bus.wb_ack_i) begin
          chk("wb_stb", 32'(bus.wb_stb_o), 32'd1);
          chk("wb_we",  32'(bus.wb_we_o),  32'd0);
          chk("wb_sel", 32'(bus.wb_sel_o), 32'hF);
          void'(exp_beat.pop_front());
        end
      end
    end
  end

  // FIFO monitor: head word compared whenever a pop is taken.
  always @(negedge clk) begin
    if (rst_n && q_rd && !q_empty) begin
      chk("q_pending", 32'(exp_dat.size() != 0), 32'd1);
      if (exp_dat.size() != 0) chk("q_dat", q_dat, exp_dat.pop_front());
    end
  end

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
  end

  task automatic pulse_start(input logic [23:0] a, input logic [13:0] n);
    base_adr = a;
    n_bursts = n;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && busy; i++) begin
      @(posedge clk); #1;
    end
    chk({name, "_busy_timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic pop_n(input int n, input string name);
    for (int k = 0; k < n; k++) begin
      int t;
      t = 0;
      while (q_empty && t < 200) begin
        @(posedge clk); #1;
        t++;
      end
      if (q_empty) begin
        chk({name, "_pop_starved"}, 32'(q_empty), 32'd0);
        return;
      end
      q_rd = 1'b1;
      @(posedge clk); #1;
      q_rd = 1'b0;
    end
  endtask

  task automatic chk_drained(input string name);
    chk({name, "_beats_left"}, 32'(exp_beat.size()), 32'd0);
    chk({name, "_words_left"}, 32'(exp_dat.size()), 32'd0);
    chk({name, "_q_empty"}, 32'(q_empty), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit seen;

    // ---- reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_cyc",   32'(bus.wb_cyc_o), 32'd0);
    chk("rst_stb",   32'(bus.wb_stb_o), 32'd0);
    chk("rst_cti",   32'(bus.wb_cti_o), 32'd0);
    chk("rst_adr",   32'(bus.wb_adr_o), 32'd0);
    chk("rst_empty", 32'(q_empty), 32'd1);
    chk("rst_level", 32'(q_level), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---- two bursts from 0x100, zero wait states
    waits = 0;
    expect_burst(24'h000100, 1'b1);
    expect_burst(24'h000110, 1'b1);
    d0 = done_cnt;
    pulse_start(24'h000100, 14'd2);
    chk("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1", 100);
    pop_n(8, "t1");
    @(posedge clk); #1;
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk_drained("t1");

    // ---- throttling: 5 bursts, FIFO holds 4
    for (int k = 0; k < 5; k++) expect_burst(24'h001000 + 24'(16 * k), 1'b1);
    d0 = done_cnt;
    pulse_start(24'h001000, 14'd5);
    repeat (60) @(posedge clk);
    #1;
    chk("t2_level_full", 32'(q_level), 32'd16);
    chk("t2_cyc_held",   32'(bus.wb_cyc_o), 32'd0);
    chk("t2_busy",       32'(busy), 32'd1);
    pop_n(4, "t2a");
    for (int i = 0; i < 3 && !bus.wb_cyc_o; i++) begin
      @(posedge clk); #1;
    end
    chk("t2_resume_cyc", 32'(bus.wb_cyc_o), 32'd1);
    pop_n(16, "t2b");
    wait_idle("t2", 100);
    @(posedge clk); #1;
    chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk_drained("t2");

    // ---- abort during beat 1 of burst 0
    expect_burst(24'h002000, 1'b0);
    d0 = done_cnt;
    pulse_start(24'h002000, 14'd3);
    for (int i = 0; i < 20 && !bus.wb_cyc_o; i++) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    wait_idle("t3", 50);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.wb_cyc_o) seen = 1'b1;
    end
    chk("t3_no_more_cyc", 32'(seen), 32'd0);
    chk("t3_level", 32'(q_level), 32'd0);
    chk("t3_done_pulses", 32'(done_cnt - d0), 32'd0);
    chk_drained("t3");

    // ---- empty transfer
    d0 = done_cnt;
    pulse_start(24'h003000, 14'd0);
    chk("t4_done_hi", 32'(done), 32'd1);
    chk("t4_busy", 32'(busy), 32'd0);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.wb_cyc_o || busy) seen = 1'b1;
    end
    chk("t4_done_lo", 32'(done), 32'd0);
    chk("t4_no_cyc_busy", 32'(seen), 32'd0);
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'd1);

    // ---- address wrap, unaligned base (low nibble ignored)
    expect_burst(24'hFFFFF0, 1'b1);
    expect_burst(24'h000000, 1'b1);
    d0 = done_cnt;
    pulse_start(24'hFFFFF5, 14'd2);
    wait_idle("t5", 100);
    pop_n(8, "t5");
    @(posedge clk); #1;
    chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk_drained("t5");

    // ---- three wait states per beat
    waits = 3;
    expect_burst(24'h000200, 1'b1);
    d0 = done_cnt;
    pulse_start(24'h000200, 14'd1);
    wait_idle("t6", 200);
    pop_n(4, "t6");
    @(posedge clk); #1;
    chk("t6_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk_drained("t6");

    // ---- reset mid-burst, then clean restart
    for (int k = 0; k < 4; k++) expect_burst(24'h000300 + 24'(16 * k), 1'b0);
    pulse_start(24'h000300, 14'd4);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(posedge clk); #1;
      if (bus.wb_cyc_o && bus.wb_ack_i) seen = 1'b1;
    end
    chk("t7_first_ack", 32'(seen), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t7_cyc",   32'(bus.wb_cyc_o), 32'd0);
    chk("t7_stb",   32'(bus.wb_stb_o), 32'd0);
    chk("t7_busy",  32'(busy), 32'd0);
    chk("t7_level", 32'(q_level), 32'd0);
    chk("t7_empty", 32'(q_empty), 32'd1);
    exp_beat.delete();
    exp_dat.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waits = 0;
    @(posedge clk); #1;
    expect_burst(24'h000400, 1'b1);
    d0 = done_cnt;
    pulse_start(24'h000400, 14'd1);
    wait_idle("t7", 100);
    pop_n(4, "t7");
    @(posedge clk); #1;
    chk("t7_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk_drained("t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
